// File: rtl/inst_fetch.sv
// IF-stage fetch engine: one outstanding SRAM-like instruction request, a registered
// output slot backed by a one-entry skid buffer, and redirect cancellation on except.
module inst_fetch #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] NOP_INST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              except,
  input  logic              stall_in,
  output logic              stall_out,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [ADDR_W-1:0] inst_rdata,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_adel
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_CANCEL} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [ADDR_W-1:0] skid_data_q, skid_data_d;
  logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
  logic              skid_adel_q, skid_adel_d;
  logic              inst_valid_q, inst_valid_d;
  logic [ADDR_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              inst_adel_q, inst_adel_d;

  logic except_hold;
  logic fault;
  logic done;
  logic slot_free;
  logic advance;

  // The redirect pulse already carries the new target on pc; no request goes out with it.
  assign except_hold = except;
  assign fault       = (state_q == S_REQ) && (pc[1:0] != 2'b00);
  assign done        = ((state_q == S_WAIT) && inst_data_ok) || fault;
  assign slot_free   = !inst_valid_q || !stall_in;
  assign advance     = (done || (state_q == S_HOLD)) && slot_free && !except;

  assign inst_req   = (state_q == S_REQ) && (pc[1:0] == 2'b00) && !except_hold;
  assign inst_addr  = pc;
  assign stall_out  = !advance;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_adel  = inst_adel_q;

  always_comb begin
    state_d      = state_q;
    req_pc_d     = req_pc_q;
    skid_data_d  = skid_data_q;
    skid_pc_d    = skid_pc_q;
    skid_adel_d  = skid_adel_q;
    inst_valid_d = inst_valid_q && stall_in;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_adel_d  = inst_adel_q;

    if (except) begin
      inst_valid_d = 1'b0;
      skid_data_d  = '0;
      skid_pc_d    = '0;
      skid_adel_d  = 1'b0;
      unique case (state_q)
        S_REQ:    state_d = (inst_req && inst_addr_ok) ? S_CANCEL : S_REQ;
        S_WAIT:   state_d = inst_data_ok ? S_REQ : S_CANCEL;
        S_HOLD:   state_d = S_REQ;
        S_CANCEL: state_d = S_CANCEL;
        default:  state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (fault) begin
            if (slot_free) begin
              inst_valid_d = 1'b1;
              inst_d       = NOP_INST;
              inst_pc_d    = pc;
              inst_adel_d  = 1'b1;
            end else begin
              skid_data_d = NOP_INST;
              skid_pc_d   = pc;
              skid_adel_d = 1'b1;
              state_d     = S_HOLD;
            end
          end else if (inst_req && inst_addr_ok) begin
            req_pc_d = pc;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (inst_data_ok) begin
            if (slot_free) begin
              inst_valid_d = 1'b1;
              inst_d       = inst_rdata;
              inst_pc_d    = req_pc_q;
              inst_adel_d  = 1'b0;
              state_d      = S_REQ;
            end else begin
              skid_data_d = inst_rdata;
              skid_pc_d   = req_pc_q;
              skid_adel_d = 1'b0;
              state_d     = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (slot_free) begin
            inst_valid_d = 1'b1;
            inst_d       = skid_data_q;
            inst_pc_d    = skid_pc_q;
            inst_adel_d  = skid_adel_q;
            state_d      = S_REQ;
          end
        end
        S_CANCEL: begin
          if (inst_data_ok) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_REQ;
      req_pc_q     <= '0;
      skid_data_q  <= '0;
      skid_pc_q    <= '0;
      skid_adel_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_adel_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_pc_q     <= req_pc_d;
      skid_data_q  <= skid_data_d;
      skid_pc_q    <= skid_pc_d;
      skid_adel_q  <= skid_adel_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_adel_q  <= inst_adel_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed cycle table, async reset sequence, then random
// bus/PC traffic scored against an output-queue model of the fetch engine.
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        exc;
  logic        stl;
  logic        stall_out;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        aok;
  logic        dok;
  logic [31:0] rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_adel;

  int checks   = 0;
  int failures = 0;

  inst_fetch #(.ADDR_W(32), .NOP_INST(32'h00000000)) dut (
    .clk(clk), .rst(rst), .pc(pc), .except(exc), .stall_in(stl),
    .stall_out(stall_out), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(aok), .inst_data_ok(dok), .inst_rdata(rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_adel(inst_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        exc, stl, aok, dok;
    logic [31:0] rdata;
    logic        e_req, e_stall, e_valid;
    logic [31:0] e_inst, e_ipc;
    logic        e_adel;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
    logic        adel;
  } ent_t;

  vec_t vq[$];
  ent_t mq[$];

  function automatic logic [31:0] rand_pc();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 7) == 0) begin
      if (r[1:0] == 2'b00) r[0] = 1'b1;
    end else begin
      r[1:0] = 2'b00;
    end
    return r;
  endfunction

  // Output-queue model state: front of mq is the slot, a second entry is the skid.
  logic        m_out, m_disc, bus_pend, adv_pc;
  logic [31:0] m_req_pc;
  logic        idle, misal, m_req, comp, pop, m_stall;
  int          msize, nsize;

  initial begin
    rst = 1'b0; pc = '0; exc = 0; stl = 0; aok = 0; dok = 0; rdata = '0;
    repeat (2) @(negedge clk);
    check1("rst_valid", inst_valid, 1'b0);
    check32("rst_inst", inst, 32'h0);
    check32("rst_inst_pc", inst_pc, 32'h0);
    check1("rst_adel", inst_adel, 1'b0);
    check1("rst_req", inst_req, 1'b1);
    rst = 1'b1;

    //               pc          exc stl aok dok rdata         req stl val inst          ipc           adel
    vq.push_back('{32'hbfc00000, 0, 0, 1, 0, 32'h0,        1, 1, 0, 32'h0,        32'h0,        0});
    vq.push_back('{32'hbfc00000, 0, 0, 0, 1, 32'h3c08bfc0, 0, 0, 0, 32'h0,        32'h0,        0});
    vq.push_back('{32'hbfc00004, 0, 1, 1, 0, 32'h0,        1, 1, 1, 32'h3c08bfc0, 32'hbfc00000, 0});
    vq.push_back('{32'hbfc00004, 0, 1, 0, 1, 32'h11111111, 0, 1, 1, 32'h3c08bfc0, 32'hbfc00000, 0});
    vq.push_back('{32'hbfc00004, 0, 1, 0, 0, 32'h0,        0, 1, 1, 32'h3c08bfc0, 32'hbfc00000, 0});
    vq.push_back('{32'hbfc00004, 0, 1, 0, 0, 32'h0,        0, 1, 1, 32'h3c08bfc0, 32'hbfc00000, 0});
    vq.push_back('{32'hbfc00004, 0, 0, 0, 0, 32'h0,        0, 0, 1, 32'h3c08bfc0, 32'hbfc00000, 0});
    vq.push_back('{32'hbfc00008, 0, 0, 1, 0, 32'h0,        1, 1, 1, 32'h11111111, 32'hbfc00004, 0});
    vq.push_back('{32'hbfc00380, 1, 0, 0, 0, 32'h0,        0, 1, 0, 32'h0,        32'h0,        0});
    vq.push_back('{32'hbfc00380, 0, 0, 0, 0, 32'h0,        0, 1, 0, 32'h0,        32'h0,        0});
    vq.push_back('{32'hbfc00380, 0, 0, 0, 0, 32'h0,        0, 1, 0, 32'h0,        32'h0,        0});
    vq.push_back('{32'hbfc00380, 0, 0, 0, 1, 32'hdeadbeef, 0, 1, 0, 32'h0,        32'h0,        0});
    vq.push_back('{32'hbfc00380, 0, 0, 1, 0, 32'h0,        1, 1, 0, 32'h0,        32'h0,        0});
    vq.push_back('{32'hbfc00500, 1, 0, 0, 1, 32'h22222222, 0, 1, 0, 32'h0,        32'h0,        0});
    vq.push_back('{32'hbfc00500, 0, 0, 0, 0, 32'h0,        1, 1, 0, 32'h0,        32'h0,        0});
    vq.push_back('{32'hbfc00500, 0, 0, 1, 0, 32'h0,        1, 1, 0, 32'h0,        32'h0,        0});
    vq.push_back('{32'hbfc00500, 0, 0, 0, 1, 32'h33333333, 0, 0, 0, 32'h0,        32'h0,        0});
    vq.push_back('{32'hbfc00002, 0, 0, 0, 0, 32'h0,        0, 0, 1, 32'h33333333, 32'hbfc00500, 0});
    vq.push_back('{32'hbfc00010, 0, 1, 0, 0, 32'h0,        1, 1, 1, 32'h00000000, 32'hbfc00002, 1});
    vq.push_back('{32'hbfc00010, 0, 0, 0, 0, 32'h0,        1, 1, 1, 32'h00000000, 32'hbfc00002, 1});
    vq.push_back('{32'hbfc00010, 0, 0, 0, 0, 32'h0,        1, 1, 0, 32'h0,        32'h0,        0});

    foreach (vq[i]) begin
      @(negedge clk);
      pc = vq[i].pc; exc = vq[i].exc; stl = vq[i].stl;
      aok = vq[i].aok; dok = vq[i].dok; rdata = vq[i].rdata;
      #1;
      check1($sformatf("vec%0d_req", i), inst_req, vq[i].e_req);
      if (vq[i].e_req) check32($sformatf("vec%0d_addr", i), inst_addr, vq[i].pc);
      check1($sformatf("vec%0d_stall_out", i), stall_out, vq[i].e_stall);
      check1($sformatf("vec%0d_valid", i), inst_valid, vq[i].e_valid);
      if (vq[i].e_valid) begin
        check32($sformatf("vec%0d_inst", i), inst, vq[i].e_inst);
        check32($sformatf("vec%0d_inst_pc", i), inst_pc, vq[i].e_ipc);
        check1($sformatf("vec%0d_adel", i), inst_adel, vq[i].e_adel);
      end
      $display("vec %0d pc=%h exc=%b stl=%b aok=%b dok=%b -> req=%b stall_out=%b valid=%b inst=%h",
               i, pc, exc, stl, aok, dok, inst_req, stall_out, inst_valid, inst);
    end

    // Asynchronous reset while a fetch is outstanding and the slot is full.
    @(negedge clk); pc = 32'hbfc00000; exc = 0; stl = 0; aok = 1; dok = 0;
    @(negedge clk); aok = 0; dok = 1; rdata = 32'haaaa5555; stl = 1;
    @(negedge clk); dok = 0; pc = 32'hbfc00004; aok = 1;
    @(negedge clk); aok = 0;
    #1;
    check1("pre_rst_valid", inst_valid, 1'b1);
    check32("pre_rst_inst", inst, 32'haaaa5555);
    check1("pre_rst_req_wait", inst_req, 1'b0);
    #1 rst = 1'b0;
    #1;
    check1("async_rst_valid", inst_valid, 1'b0);
    check32("async_rst_inst", inst, 32'h0);
    check32("async_rst_inst_pc", inst_pc, 32'h0);
    check1("async_rst_req", inst_req, 1'b1);
    check1("async_rst_stall_out", stall_out, 1'b1);
    $display("async reset mid-wait: valid=%b req=%b", inst_valid, inst_req);
    @(negedge clk); stl = 0; pc = 32'hbfc00000; rst = 1'b1;

    m_out = 0; m_disc = 0; bus_pend = 0; adv_pc = 0; m_req_pc = '0;
    mq.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (adv_pc) pc = rand_pc();
      dok   = bus_pend && ($urandom_range(0, 1) == 1);
      rdata = $urandom;
      exc   = !dok && ($urandom_range(0, 15) == 0);
      if (exc) pc = rand_pc();
      stl   = ($urandom_range(0, 2) == 0);
      aok   = 1'b0;
      #1;
      msize   = mq.size();
      idle    = !m_out && !m_disc && (msize < 2);
      misal   = (pc[1:0] != 2'b00);
      m_req   = idle && !misal && !exc;
      comp    = !exc && ((m_out && dok) || (idle && misal));
      pop     = (msize > 0) && !stl;
      nsize   = msize - int'(pop) + int'(comp);
      m_stall = !(!exc && (comp || msize == 2) && nsize == 1);

      check1("rnd_valid", inst_valid, msize > 0);
      if (msize > 0) begin
        check32("rnd_inst", inst, mq[0].data);
        check32("rnd_inst_pc", inst_pc, mq[0].pc);
        check1("rnd_adel", inst_adel, mq[0].adel);
      end
      check1("rnd_req", inst_req, m_req);
      if (m_req) check32("rnd_addr", inst_addr, pc);
      aok = inst_req && !bus_pend && ($urandom_range(0, 1) == 1);
      #1;
      check1("rnd_stall_out", stall_out, m_stall);
      $display("rnd %0d pc=%h exc=%b stl=%b aok=%b dok=%b q=%0d req=%b stall_out=%b",
               cyc, pc, exc, stl, aok, dok, msize, inst_req, stall_out);

      if (exc) begin
        mq.delete();
        if (m_out) begin
          m_out  = 1'b0;
          m_disc = !dok;
        end
      end else begin
        if (pop) void'(mq.pop_front());
        if (comp) begin
          if (m_out) mq.push_back('{rdata, m_req_pc, 1'b0});
          else       mq.push_back('{32'h00000000, pc, 1'b1});
        end
        if (m_out && dok) m_out = 1'b0;
        else if (m_disc && dok) m_disc = 1'b0;
        else if (m_req && aok) begin
          m_out    = 1'b1;
          m_req_pc = pc;
        end
      end
      if (dok) bus_pend = 1'b0;
      if (inst_req && aok) bus_pend = 1'b1;
      adv_pc = !m_stall;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
